// File: rtl/acc_bank_pkg.sv
// Shared encodings and lane-geometry helpers for the accumulator bank.
// Lanes are built from four equal segments; these helpers say, for a given
// mode, which segment starts a lane, which one ends it, and which lane it is.
package acc_bank_pkg;

  typedef enum logic [1:0] {
    OpAcc   = 2'd0,
    OpLoad  = 2'd1,
    OpDrain = 2'd2,
    OpNop   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    Mode1x32 = 2'd0,
    Mode2x16 = 2'd1,
    Mode4x8  = 2'd2,
    ModeRsvd = 2'd3
  } mode_e;

  localparam int unsigned NumSeg = 4;

  // Segment index holding the sign bit of the lane that contains seg.
  function automatic logic [1:0] lane_top(input logic [1:0] mode, input logic [1:0] seg);
    logic [1:0] top;
    case (mode)
      Mode2x16: top = {seg[1], 1'b1};
      Mode4x8:  top = seg;
      default:  top = 2'd3;  // 1x32 and the reserved encoding
    endcase
    return top;
  endfunction

  // Lane number (flag bit) owning segment seg.
  function automatic logic [1:0] lane_idx(input logic [1:0] mode, input logic [1:0] seg);
    logic [1:0] idx;
    case (mode)
      Mode2x16: idx = {1'b0, seg[1]};
      Mode4x8:  idx = seg;
      default:  idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when seg is the least significant segment of its lane (carry-in killed).
  function automatic logic seg_is_lsb(input logic [1:0] mode, input logic [1:0] seg);
    logic lsb;
    case (mode)
      Mode2x16: lsb = ~seg[0];
      Mode4x8:  lsb = 1'b1;
      default:  lsb = (seg == 2'd0);
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/acc_lane_adder.sv
// Lane-splittable adder: 1x32, 2x16 or 4x8 signed lanes with carry kill at
// lane boundaries and per-lane signed overflow detect.
// Build option: define ACC_SAT_EN to clamp overflowing lanes to their signed
// max/min; otherwise lanes wrap. Overflow flags are produced either way.
module acc_lane_adder
  import acc_bank_pkg::*;
#(
  parameter int unsigned MAC_MIN_WIDTH = 8,
  parameter int unsigned MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
  input  logic [MAC_ACC_WIDTH-1:0] a,
  input  logic [MAC_ACC_WIDTH-1:0] b,
  input  logic [1:0]               mode,
  output logic [MAC_ACC_WIDTH-1:0] sum,
  output logic [3:0]               ovf
);

  localparam int unsigned Sw = MAC_MIN_WIDTH;

  logic [MAC_ACC_WIDTH-1:0] raw;
  logic [Sw:0]              seg_sum;
  logic                     carry;
  logic                     seg_cin;

  // Segment-wise ripple; the carry between segments is dropped at lane starts.
  always_comb begin
    raw     = '0;
    seg_sum = '0;
    carry   = 1'b0;
    seg_cin = 1'b0;
    for (int s = 0; s < NumSeg; s++) begin
      seg_cin = seg_is_lsb(mode, 2'(s)) ? 1'b0 : carry;
      seg_sum = {1'b0, a[s*Sw +: Sw]} + {1'b0, b[s*Sw +: Sw]} + {{Sw{1'b0}}, seg_cin};
      raw[s*Sw +: Sw] = seg_sum[Sw-1:0];
      carry = seg_sum[Sw];
    end
  end

  // Signed overflow per lane: operands agree in sign, result does not.
  always_comb begin
    ovf = 4'b0;
    for (int s = 0; s < NumSeg; s++) begin
      if (lane_top(mode, 2'(s)) == 2'(s)) begin
        if ((a[s*Sw+Sw-1] == b[s*Sw+Sw-1]) && (raw[s*Sw+Sw-1] != a[s*Sw+Sw-1])) begin
          ovf[lane_idx(mode, 2'(s))] = 1'b1;
        end
      end
    end
  end

`ifdef ACC_SAT_EN
  logic [1:0] top;
  logic       neg;

  // Clamp: the operand sign of an overflowing lane selects max or min.
  always_comb begin
    sum = raw;
    top = 2'd0;
    neg = 1'b0;
    for (int s = 0; s < NumSeg; s++) begin
      top = lane_top(mode, 2'(s));
      neg = a[32'(top)*Sw+Sw-1];
      if (ovf[lane_idx(mode, 2'(s))]) begin
        sum[s*Sw +: Sw] = (top == 2'(s)) ? {neg, {(Sw-1){~neg}}} : {Sw{~neg}};
      end
    end
  end
`else
  // Wrapping lanes: the raw segmented sum is the result.
  always_comb begin
    sum = raw;
  end
`endif

endmodule

// File: rtl/acc_bank.sv
// Multi-entry lane-splittable accumulator bank with valid/ready request and
// drain ports. One request stage feeds a read-modify-write on a register-array
// bank; DRAIN results sit in an output register until accepted downstream.
// Build option: ACC_SAT_EN (saturating lanes, see acc_lane_adder).
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int unsigned MAC_MIN_WIDTH = 8,
  parameter int unsigned MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int unsigned NUM_ACC       = 4,
  parameter int unsigned ADDR_W        = $clog2(NUM_ACC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [1:0]               in_mode,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [MAC_ACC_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [MAC_ACC_WIDTH-1:0] out_data,
  output logic [3:0]               out_ovf
);

  // Request stage
  logic                     st_valid_q;
  op_e                      st_op_q;
  logic [1:0]               st_mode_q;
  logic [ADDR_W-1:0]        st_addr_q;
  logic [MAC_ACC_WIDTH-1:0] st_data_q;

  // Bank state
  logic [MAC_ACC_WIDTH-1:0] bank_q  [NUM_ACC];
  logic [3:0]               flags_q [NUM_ACC];

  // Output register
  logic                     out_valid_q;
  logic [ADDR_W-1:0]        out_addr_q;
  logic [MAC_ACC_WIDTH-1:0] out_data_q;
  logic [3:0]               out_ovf_q;

  logic                     exec;
  logic                     accept;
  logic                     addr_ok;
  logic [MAC_ACC_WIDTH-1:0] rd_bank;
  logic [3:0]               rd_flags;
  logic [MAC_ACC_WIDTH-1:0] add_sum;
  logic [3:0]               add_ovf;

  // A staged DRAIN may only execute if the output register is free or leaving.
  always_comb begin
    exec     = st_valid_q && !(st_op_q == OpDrain && out_valid_q && !out_ready);
    in_ready = !st_valid_q || exec;
    accept   = in_valid && in_ready;
  end

  // Bank read for the staged address; out-of-range addresses read as zero.
  always_comb begin
    addr_ok  = (32'(st_addr_q) < NUM_ACC);
    rd_bank  = '0;
    rd_flags = 4'b0;
    if (addr_ok) begin
      rd_bank  = bank_q[st_addr_q];
      rd_flags = flags_q[st_addr_q];
    end
  end

  acc_lane_adder #(
    .MAC_MIN_WIDTH (MAC_MIN_WIDTH),
    .MAC_ACC_WIDTH (MAC_ACC_WIDTH)
  ) u_adder (
    .a    (rd_bank),
    .b    (st_data_q),
    .mode (st_mode_q),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // Stage register: load on handshake, empty once executed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid_q <= 1'b0;
      st_op_q    <= OpNop;
      st_mode_q  <= 2'd0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
    end else if (accept) begin
      st_valid_q <= 1'b1;
      st_op_q    <= op_e'(in_op);
      st_mode_q  <= in_mode;
      st_addr_q  <= in_addr;
      st_data_q  <= in_data;
    end else if (exec) begin
      st_valid_q <= 1'b0;
    end
  end

  // Bank and sticky flag updates for the executing request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        bank_q[i]  <= '0;
        flags_q[i] <= 4'b0;
      end
    end else if (exec && addr_ok) begin
      unique case (st_op_q)
        OpAcc: begin
          bank_q[st_addr_q]  <= add_sum;
          flags_q[st_addr_q] <= rd_flags | add_ovf;
        end
        OpLoad: begin
          bank_q[st_addr_q]  <= st_data_q;
          flags_q[st_addr_q] <= 4'b0;
        end
        OpDrain: begin
          bank_q[st_addr_q]  <= '0;
          flags_q[st_addr_q] <= 4'b0;
        end
        OpNop: ;
      endcase
    end
  end

  // Output register: a new DRAIN overwrites; otherwise clear on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 4'b0;
    end else if (exec && st_op_q == OpDrain) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= st_addr_q;
      out_data_q  <= rd_bank;
      out_ovf_q   <= rd_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/acc_bank.md
# acc_bank

Multi-entry, lane-splittable accumulator bank for the MAC datapath. It is the parametrised successor of the single-register accumulator. It holds NUM_ACC independent accumulators, and each one can run as 1×32, 2×16 or 4×8 lanes by breaking the carry chain. Requests arrive over a valid/ready handshake and results drain over a second valid/ready port, so the bank can sit between the multiplier array and the writeback path.

## Interface
- MAC_MIN_WIDTH, 8, lane width in 4×8 mode
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, accumulator width
- NUM_ACC, 4, number of accumulators (≥2)
- ADDR_W, $clog2(NUM_ACC), address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  2  0 ACC, 1 LOAD, 2 DRAIN, 3 NOP
- in_mode  in  2  0 MODE_1X32, 1 MODE_2X16, 2 MODE_4X8, 3 reserved (treated as MODE_1X32)
- in_addr  in  ADDR_W  target accumulator
- in_data  in  MAC_ACC_WIDTH  addend (ACC) or load value (LOAD)
- out_valid  out  1  drain result valid
- out_ready  in  1  downstream accepts drain result
- out_addr  out  ADDR_W  accumulator that was drained
- out_data  out  MAC_ACC_WIDTH  drained value
- out_ovf  out  4  sticky per-lane overflow flags of the drained accumulator

## Operation
- **Stage register.** One request stage (st_valid, op, mode, addr, data) is loaded on each accepted handshake.
- **Execute condition.** exec = st_valid && !(st_op==DRAIN && out_valid && !out_ready).
- **Ready.** in_ready = !st_valid || exec. This is combinational from out_valid/out_ready/stage only, never from in_valid.
- **ACC on exec.** bank[addr] <= lanewise(bank[addr] + data).
  - Lanes: MODE_1X32 one lane; MODE_2X16 two lanes of MAC_ACC_WIDTH/2; MODE_4X8 four lanes of MAC_MIN_WIDTH.
  - No carry crosses a lane boundary.
  - Operands are two's complement signed per lane.
- **Overflow flags.**
  - A lane sets its flag on signed overflow: equal operand signs and a differing result sign.
  - Per-bank flags are 4 bits. In MODE_1X32 only bit 0 is used. In MODE_2X16 bits 0–1 are used.
  - Flags are sticky until LOAD or DRAIN of that bank.
- **LOAD on exec.** bank[addr] <= data; flags[addr] <= 0.
- **DRAIN on exec.**
  - out_data <= bank[addr], out_addr <= addr, out_ovf <= flags[addr], out_valid <= 1.
  - Then bank[addr] <= 0 and flags[addr] <= 0.
- **NOP.** Consumes a slot; no state change.
- **Output handshake.** out_valid clears on out_valid && out_ready unless a new DRAIN executes in the same cycle; in that case the new result replaces the old one and out_valid stays 1.
- **Mode per request.** Mode is carried with each request and is not stored per bank. Mixing modes on one bank is legal; the result is purely bitwise per the current mode.

## Timing
- **Reset.** All banks 0, all flags 0, st_valid 0, out_valid 0, out_data 0, out_addr 0, out_ovf 0, in_ready 1. Reset asserted mid-operation discards the staged request and the pending output immediately.
- **Write latency.** A request accepted at edge N updates the bank at edge N+1.
- **Back-to-back requests.** Requests to the same address are correct with no bubble. The read-modify-write reads the bank in the exec cycle, and the previous write has completed by then.
- **Drain latency.** A DRAIN accepted at edge N gives out_valid at N+1, if the output is free or is accepted in that cycle.
- **Throughput.** One request per cycle unless a DRAIN is blocked by the output.
- **Stall.** While stalled, in_ready=0 and the stage holds its contents.

## Configuration
- `ACC_SAT_EN` defined:
  - An overflowing lane clamps to its signed max (positive overflow) or min (negative overflow).
  - The flag is still set.
- Undefined:
  - Lanes wrap modulo 2^lane_width.
  - Flags behave identically.

## Structure
- Op and mode encodings (ACC/LOAD/DRAIN/NOP, MODE_*) go as `define constants in shared mac_const.vh.
- Sub-module acc_lane_adder:
  - Inputs: A, B, mode. Outputs: SUM, ovf[3:0].
  - Carry kill at lane boundaries; optional saturation under ACC_SAT_EN.
- The bank is a register array, not a RAM macro.

## Test plan
- **Reset/load/drain.** Reset; LOAD addr1=0x00000010; ACC addr1 +0x00000005; DRAIN addr1 → out_data=0x00000015, out_ovf=0, out_addr=1; a following DRAIN addr1 → 0.
- **4×8 lanes.** MODE_4X8; LOAD addr0=0x7F01FF10; ACC +0x01010101.
  - Without `ACC_SAT_EN`: DRAIN → 0x80020011, out_ovf=4'b1000.
  - With `ACC_SAT_EN`: DRAIN → 0x7F020011, out_ovf=4'b1000.
- **2×16 carry isolation.** LOAD 0x0000FFFF; ACC +0x00000001 → 0x00000000, ovf=0.
- **1×32 overflow.** LOAD 0x7FFFFFFF; ACC +1 → wrap 0x80000000 (or 0x7FFFFFFF with `ACC_SAT_EN`), out_ovf=4'b0001.
- **Backpressure.** out_ready=0; DRAIN addr2, then DRAIN addr3 → second request stalls with in_ready=0 and out_data stays at the addr2 value; raise out_ready → addr3 result on the next cycle, no loss.
- **Async reset.** Async reset asserted mid-stream between edges → out_valid drops immediately and all banks read 0 afterwards.
